// File: rtl/dmux_stream.sv
// dmux_stream: 1:CHANNELS valid/ready stream demultiplexer with a DEPTH-entry
// FIFO on every output channel.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   in_valid/ready producer handshake; in_ready never depends on out_ready
//   in_data        input word
//   in_sel         target channel for unicast words
//   in_bcast       1 = write the word into every channel FIFO at once
//   out_valid[c]   channel c FIFO non-empty
//   out_ready[c]   consumer c takes the head word
//   out_data       channel c head word at [c*WIDTH +: WIDTH]
//   ch_full[c]     channel c holds DEPTH words
//   drop_count     saturating count of words discarded for out-of-range in_sel
module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       ch_full,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem    [CHANNELS][DEPTH];
  logic [PTR_W-1:0] wr_ptr [CHANNELS];
  logic [PTR_W-1:0] rd_ptr [CHANNELS];
  logic [CNT_W-1:0] count  [CHANNELS];
  logic [15:0]      drop_q;

  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic                sel_ok;
  logic                accept;
  logic                drop;

  // Decode in_sel as a one-hot match against each channel index; an
  // out-of-range select simply matches nothing, which avoids a magnitude
  // compare that is constant whenever 2**SEL_W == CHANNELS.
  always_comb begin
    sel_hit  = '0;
    full     = '0;
    nonempty = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sel_hit[c]  = (in_sel == SEL_W'(c));
      full[c]     = (count[c] == CNT_W'(DEPTH));
      nonempty[c] = (count[c] != '0);
    end
  end

  always_comb begin
    sel_ok = |sel_hit;
    if (in_bcast)
      in_ready = ~|full;
    else if (sel_ok)
      in_ready = |(sel_hit & ~full);
    else
      in_ready = 1'b1;
    accept = in_valid & in_ready;
    push   = '0;
    if (accept)
      push = in_bcast ? '1 : sel_hit;
    pop  = nonempty & out_ready;
    drop = accept & ~in_bcast & ~sel_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        for (int unsigned d = 0; d < DEPTH; d++)
          mem[c][d] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_data;
          wr_ptr[c]         <= wr_ptr[c] + PTR_W'(1);
        end
        if (pop[c])
          rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + CNT_W'(1);
          2'b01:   count[c] <= count[c] - CNT_W'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (drop && (drop_q != '1))
      drop_q <= drop_q + 16'd1;
  end

  always_comb begin
    out_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      out_data[c*WIDTH +: WIDTH] = mem[c][rd_ptr[c]];
  end

  assign out_valid  = nonempty;
  assign ch_full    = full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dmux_stream.sv
module tb_dmux_stream;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_bcast = 1'b0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic [4*W-1:0] out_data;
  logic [3:0]    ch_full;
  logic [15:0]   drop_count;

  // 3-channel instance (out-of-range select)
  logic          in_valid3 = 1'b0;
  logic          in_ready3;
  logic [W-1:0]  in_data3 = '0;
  logic [1:0]    in_sel3 = '0;
  logic          in_bcast3 = 1'b0;
  logic [2:0]    out_valid3;
  logic [2:0]    out_ready3 = '1;
  logic [3*W-1:0] out_data3;
  logic [2:0]    ch_full3;
  logic [15:0]   drop_count3;

  dmux_stream #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ch_full(ch_full), .drop_count(drop_count)
  );

  dmux_stream #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .DEPTH(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .ch_full(ch_full3), .drop_count(drop_count3)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] sb [4][$];
  int pop_cnt [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are sampled at negedge, i.e. they describe the
  // transfer that the next rising edge performs.
  task automatic monitor();
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < 4; c++) begin
          if (out_valid[c] && out_ready[c]) begin
            got_w = out_data[c*W +: W];
            tests_run++;
            if (sb[c].size() == 0) begin
              tests_failed++;
              $display("FAIL sb_pop ch%0d: got %h, expected no word", c, got_w);
            end else begin
              exp_w = sb[c].pop_front();
              if (got_w !== exp_w) begin
                tests_failed++;
                $display("FAIL sb_data ch%0d: got %h, expected %h", c, got_w, exp_w);
              end
            end
            pop_cnt[c]++;
          end
        end
        if (in_valid && in_ready) begin
          if (in_bcast) begin
            for (int c = 0; c < 4; c++) sb[c].push_back(in_data);
          end else begin
            sb[in_sel].push_back(in_data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL rst_out_valid: got %b, expected 0000", out_valid); end
    tests_run++;
    if (ch_full !== 4'b0000) begin tests_failed++; $display("FAIL rst_ch_full: got %b, expected 0000", ch_full); end
    tests_run++;
    if (drop_count !== 16'h0000) begin tests_failed++; $display("FAIL rst_drop_count: got %h, expected 0000", drop_count); end
    tests_run++;
    if (out_data !== '0) begin tests_failed++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unicast();
    out_ready = 4'hF;
    in_data = 16'hA001; in_sel = 2'd2; in_bcast = 1'b0; in_valid = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL uni_in_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 4'b0100) begin tests_failed++; $display("FAIL uni_out_valid: got %b, expected 0100", out_valid); end
    tests_run++;
    if (out_data[2*W +: W] !== 16'hA001) begin tests_failed++; $display("FAIL uni_data: got %h, expected a001", out_data[2*W +: W]); end
    tick();
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL uni_drained: got %b, expected 0000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    in_sel = 2'd1; in_bcast = 1'b0;
    in_data = 16'h0011; in_valid = 1'b1;
    tick();
    in_data = 16'h0012;
    tick();
    in_data = 16'h0013;
    tests_run++;
    if (ch_full !== 4'b0010) begin tests_failed++; $display("FAIL bp_ch_full: got %b, expected 0010", ch_full); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_full: got %b, expected 0", in_ready); end
    tick();
    tick();
    tests_run++;
    if (out_data[W +: W] !== 16'h0011 || out_valid[1] !== 1'b1) begin
      tests_failed++; $display("FAIL bp_hold: got v=%b d=%h, expected v=1 d=0011", out_valid[1], out_data[W +: W]);
    end
    out_ready = 4'hF;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_no_credit: got %b, expected 0", in_ready); end
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_data[W +: W] !== 16'h0012) begin
      tests_failed++; $display("FAIL bp_after_pop: got rdy=%b d=%h, expected rdy=1 d=0012", in_ready, out_data[W +: W]);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_data[W +: W] !== 16'h0013) begin tests_failed++; $display("FAIL bp_third: got %h, expected 0013", out_data[W +: W]); end
    tick();
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL bp_drained: got %b, expected 0000", out_valid); end
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0111;
    in_sel = 2'd3; in_bcast = 1'b0; in_valid = 1'b1;
    in_data = 16'h3001;
    tick();
    in_data = 16'h3002;
    tick();
    in_bcast = 1'b1; in_data = 16'hBEEF;
    tests_run++;
    if (ch_full !== 4'b1000) begin tests_failed++; $display("FAIL bc_ch_full: got %b, expected 1000", ch_full); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bc_blocked: got %b, expected 0", in_ready); end
    tick();
    out_ready = 4'hF;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bc_no_credit: got %b, expected 0", in_ready); end
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bc_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    tests_run++;
    if (out_valid !== 4'hF) begin tests_failed++; $display("FAIL bc_all_valid: got %b, expected 1111", out_valid); end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (out_data[c*W +: W] !== 16'hBEEF) begin
        tests_failed++; $display("FAIL bc_data ch%0d: got %h, expected beef", c, out_data[c*W +: W]);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 4'b0000 || drop_count !== 16'h0000) begin
      tests_failed++; $display("FAIL bc_after: got v=%b drop=%h, expected v=0000 drop=0000", out_valid, drop_count);
    end
  endtask

  task automatic test_stream();
    int base;
    base = pop_cnt[0];
    out_ready = 4'hF;
    in_sel = 2'd0; in_bcast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'h0C00 + 16'(i);
      in_valid = 1'b1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL st_in_ready %0d: got %b, expected 1", i, in_ready); end
      tick();
      tests_run++;
      if (out_valid[0] !== 1'b1 || ch_full[0] !== 1'b0) begin
        tests_failed++; $display("FAIL st_level %0d: got v=%b f=%b, expected v=1 f=0", i, out_valid[0], ch_full[0]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (pop_cnt[0] - base != 10 || out_valid !== 4'b0000) begin
      tests_failed++; $display("FAIL st_count: got pops=%0d v=%b, expected pops=10 v=0000", pop_cnt[0] - base, out_valid);
    end
  endtask

  task automatic test_drop();
    in_sel3 = 2'd3; in_bcast3 = 1'b0; in_data3 = 16'h7777; in_valid3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (in_ready3 !== 1'b1) begin tests_failed++; $display("FAIL drop_ready %0d: got %b, expected 1", i, in_ready3); end
      tick();
      tests_run++;
      if (out_valid3 !== 3'b000) begin tests_failed++; $display("FAIL drop_out_valid %0d: got %b, expected 000", i, out_valid3); end
    end
    in_valid3 = 1'b0;
    tests_run++;
    if (drop_count3 !== 16'd5) begin tests_failed++; $display("FAIL drop_count5: got %h, expected 0005", drop_count3); end
    in_sel3 = 2'd0; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    tests_run++;
    if (drop_count3 !== 16'd5 || out_valid3 !== 3'b001) begin
      tests_failed++; $display("FAIL drop_valid_uni: got drop=%h v=%b, expected drop=0005 v=001", drop_count3, out_valid3);
    end
    tick();
    force dut3.drop_q = 16'hFFFD;
    #1;
    release dut3.drop_q;
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid3 = 1'b0;
    tests_run++;
    if (drop_count3 !== 16'hFFFF) begin tests_failed++; $display("FAIL drop_saturate: got %h, expected ffff", drop_count3); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 4'h0;
    in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
    in_data = 16'h0101;
    tick();
    in_data = 16'h0102;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (ch_full !== 4'b0001) begin tests_failed++; $display("FAIL mid_queued: got %b, expected 0001", ch_full); end
    #2;
    rst = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) sb[c].delete();
    tests_run++;
    if (out_valid !== 4'b0000 || ch_full !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rst_flags: got v=%b f=%b, expected 0000 0000", out_valid, ch_full);
    end
    tests_run++;
    if (drop_count !== 16'h0 || drop_count3 !== 16'h0 || out_data !== '0) begin
      tests_failed++; $display("FAIL mid_rst_state: got drop=%h drop3=%h data=%h, expected zeros", drop_count, drop_count3, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    out_ready = 4'hF;
    in_data = 16'h5A5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 4'b0001 || out_data[W-1:0] !== 16'h5A5A) begin
      tests_failed++; $display("FAIL mid_first: got v=%b d=%h, expected v=0001 d=5a5a", out_valid, out_data[W-1:0]);
    end
    tick();
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL mid_alone: got %b, expected 0000", out_valid); end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) pop_cnt[c] = 0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
      end
    join_none
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_stream();
    test_drop();
    test_reset_midstream();
    tick();
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (sb[c].size() != 0) begin
        tests_failed++; $display("FAIL sb_leftover ch%0d: got %0d words, expected 0", c, sb[c].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised 1:CHANNELS stream demultiplexer with valid/ready handshakes and a DEPTH-entry FIFO per output channel.
- Supports a unicast mode, steered by in_sel, and a broadcast mode that writes one word to every channel in the same cycle.
- Sits between a single producer (datapath/memory bus) and several independent consumers, so a stalled consumer does not block others unless the word targets it.
- Counts words dropped because of an out-of-range select.

Parameters:
WIDTH, 16, data word width in bits
CHANNELS, 4, number of output channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS
DEPTH, 2, FIFO entries per channel; power of two, >= 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
in_valid  input  1  producer has a word
in_ready  output  1  block accepts the word this cycle
in_data  input  WIDTH  word
in_sel  input  SEL_W  target channel (unicast)
in_bcast  input  1  1 = write to all channels; in_sel ignored
out_valid  output  CHANNELS  bit c: channel c FIFO non-empty
out_ready  input  CHANNELS  bit c: consumer c takes head word
out_data  output  CHANNELS*WIDTH  channel c head word at bits [c*WIDTH +: WIDTH]
ch_full  output  CHANNELS  bit c: channel c holds DEPTH words
drop_count  output  16  saturating count of dropped words

Behaviour:
- Reset values (async, asserted or mid-operation):
  - all FIFO counts, read pointers and write pointers = 0
  - out_valid = 0, ch_full = 0, drop_count = 0, out_data = 0 (storage cleared)
  - any in-flight contents are discarded.
- accept = in_valid & in_ready. pop[c] = out_valid[c] & out_ready[c].
- in_ready is combinational from registered state and the select inputs only; it never depends on out_ready:
  - in_bcast=1: in_ready = 1 only when no channel is full (every bit of ch_full is 0).
  - in_bcast=0, in_sel < CHANNELS: in_ready = ~ch_full[in_sel].
  - in_bcast=0, in_sel >= CHANNELS: in_ready = 1. The word is discarded and drop_count increments, saturating at 16'hFFFF.
- Push on accept:
  - unicast writes only FIFO in_sel
  - broadcast writes every FIFO at its own write pointer in the same cycle.
- Latency: a word accepted on edge N appears on out_valid/out_data after edge N (visible in cycle N+1). No combinational in-to-out path.
- Per-channel state is count (0..DEPTH), wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH.
  - out_valid[c] = (count != 0); ch_full[c] = (count == DEPTH).
  - out_data for channel c = storage[c][rd_ptr]. It holds stable while out_valid[c] & ~out_ready[c].
- Count update per channel:
  - push only: +1
  - pop only: −1
  - push and pop same cycle: unchanged, both pointers advance
  - neither: unchanged.
- Boundaries:
  - Full channel with pop in the same cycle: in_ready stays 0 for that channel in that cycle; no same-cycle credit.
  - Empty channel: a pop cannot occur because out_valid=0; out_ready is ignored.
  - Pointer wrap DEPTH−1 → 0 is seamless; per-channel order is strictly FIFO.
  - Channels are independent: consumer stalls affect only unicasts to that channel, and broadcasts.
  - drop_count does not change on accepted broadcasts or valid unicasts.
- Upstream protocol: in_data, in_sel and in_bcast must hold while in_valid & ~in_ready. The block does not check this.

Test Plan:
- Reset, then unicast 16'hA001 sel=2 with all out_ready=1 → out_valid=4'b0100 in the next cycle, data 16'hA001, then 0; other channels idle.
- out_ready[1]=0; send 16'h0011, 16'h0012, 16'h0013 to sel=1 → first two accepted, ch_full[1]=1, in_ready=0 on the third. Raise out_ready[1] → output 0011, 0012, then 0013 in order.
- in_bcast=1 with 16'hBEEF while channel 3 is full → in_ready=0. Drain channel 3 → accepted; all four out_valid bits go high with 16'hBEEF.
- CHANNELS=3 build, in_sel=3, 5 words → in_ready=1 each cycle, drop_count=5, out_valid stays 0. Preload drop_count near saturation → holds at 16'hFFFF.
- Channel 0 steady stream, in_valid and out_ready[0] high for 10 cycles → one word per cycle, count constant, pointers wrap, output sequence matches input.
- Assert rst asynchronously mid-stream with 2 words queued → out_valid=0, drop_count=0 immediately. First post-reset word appears alone.
